// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and master state type
package axi_lite_pkg;

   localparam logic [1:0] RSP_OKAY   = 2'b00;
   localparam logic [1:0] RSP_EXOKAY = 2'b01;
   localparam logic [1:0] RSP_SLVERR = 2'b10;
   localparam logic [1:0] RSP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WR_RESP,
      ST_READ,
      ST_RD_RESP,
      ST_RSP,
      ST_DRAIN
   } master_state_e;

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// rtl/axi_lite_cmd_master_if.sv - AXI-Lite bus bundle with master/slave views
interface axi_lite_cmd_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      awvalid;
   logic                      awready;
   logic [ADDR_WIDTH-1:0]     awaddr;
   logic [2:0]                awprot;
   logic                      wvalid;
   logic                      wready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      bvalid;
   logic                      bready;
   logic [1:0]                bresp;
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic [2:0]                arprot;
   logic                      rvalid;
   logic                      rready;
   logic [DATA_WIDTH-1:0]     rdata;
   logic [1:0]                rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - command stream to single AXI-Lite transaction bridge
module axi_lite_cmd_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_timeout,
   axi_lite_cmd_master_if.master     m_axi
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   master_state_e           state_q, state_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              resp_q, resp_d;
   logic                    timeout_q, timeout_d;
   logic                    expired;

   assign expired = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

   assign m_axi.awaddr = addr_q;
   assign m_axi.awprot = 3'b000;
   assign m_axi.wdata  = wdata_q;
   assign m_axi.wstrb  = wstrb_q;
   assign m_axi.araddr = addr_q;
   assign m_axi.arprot = 3'b000;

   assign rsp_rdata   = rdata_q;
   assign rsp_resp    = resp_q;
   assign rsp_timeout = timeout_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         resp_q    <= RSP_OKAY;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      cnt_d         = cnt_q;
      rdata_d       = rdata_q;
      resp_d        = resp_q;
      timeout_d     = timeout_q;
      cmd_ready     = 1'b0;
      rsp_valid     = 1'b0;
      m_axi.awvalid = 1'b0;
      m_axi.wvalid  = 1'b0;
      m_axi.bready  = 1'b0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               write_d   = cmd_write;
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               timeout_d = 1'b0;
               state_d   = cmd_write ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            // AW and W retire independently; each valid drops after its own handshake
            m_axi.awvalid = !aw_done_q;
            m_axi.wvalid  = !w_done_q;
            aw_done_d     = aw_done_q | m_axi.awready;
            w_done_d      = w_done_q | m_axi.wready;
            if (aw_done_d && w_done_d) begin
               cnt_d   = '0;
               state_d = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            m_axi.bready = 1'b1;
            cnt_d        = cnt_q + 1'b1;
            if (m_axi.bvalid) begin
               resp_d  = m_axi.bresp;
               rdata_d = '0;
               state_d = ST_RSP;
            end else if (expired) begin
               resp_d    = RSP_SLVERR;
               rdata_d   = '0;
               timeout_d = 1'b1;
               state_d   = ST_RSP;
            end
         end
         ST_READ: begin
            m_axi.arvalid = 1'b1;
            if (m_axi.arready) begin
               cnt_d   = '0;
               state_d = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            m_axi.rready = 1'b1;
            cnt_d        = cnt_q + 1'b1;
            if (m_axi.rvalid) begin
               resp_d  = m_axi.rresp;
               rdata_d = m_axi.rdata;
               state_d = ST_RSP;
            end else if (expired) begin
               resp_d    = RSP_SLVERR;
               rdata_d   = '0;
               timeout_d = 1'b1;
               state_d   = ST_RSP;
            end
         end
         ST_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = timeout_q ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // The slave still owes a B/R beat; swallow it before taking new work
            m_axi.bready = write_q;
            m_axi.rready = !write_q;
            if (write_q ? m_axi.bvalid : m_axi.rvalid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (reset) begin
         cmd_ready     = 1'b0;
         rsp_valid     = 1'b0;
         m_axi.awvalid = 1'b0;
         m_axi.wvalid  = 1'b0;
         m_axi.bready  = 1'b0;
         m_axi.arvalid = 1'b0;
         m_axi.rready  = 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - scoreboard bench for axi_lite_cmd_master
module tb_axi_lite_cmd_master;
   import axi_lite_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;

   axi_lite_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

   axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_wstrb   (cmd_wstrb),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_resp    (rsp_resp),
      .rsp_timeout (rsp_timeout),
      .m_axi       (m_axi)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        to;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem[logic [31:0]];

   function automatic logic is_mapped(input logic [31:0] a);
      return a < 32'h100;
   endfunction

   function automatic logic [31:0] unmapped_data(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // ---------------- slave model ----------------
   int  aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   bit  hang = 1'b0;
   int  aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   bit  got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
   logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
   logic [3:0]  s_wstrb = '0;
   logic [1:0]  s_bresp = '0;
   logic [31:0] slv_mem[logic [31:0]];
   logic sn_awv = 0, sn_awr = 0, sn_wv = 0, sn_wr = 0, sn_bv = 0, sn_br = 0;
   logic sn_arv = 0, sn_arr = 0, sn_rv = 0, sn_rr = 0;
   logic [31:0] sn_awaddr = '0, sn_wdata = '0, sn_araddr = '0;
   logic [3:0]  sn_wstrb = '0;
   int  sn_cyc = 0;
   int  aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, ar_hs_cyc = 0, r_hs_cyc = 0;
   int  b_hs_count = 0, r_hs_count = 0, wv_cycles = 0;

   always @(negedge clk) begin
      if (reset) begin
         got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
         m_axi.awready = 0; m_axi.wready = 0; m_axi.arready = 0;
         m_axi.bvalid = 0; m_axi.bresp = 0; m_axi.rvalid = 0;
         m_axi.rdata = 0; m_axi.rresp = 0;
      end else begin
         if (sn_wv) wv_cycles++;
         if (sn_awv && sn_awr) begin
            got_aw = 1; s_awaddr = sn_awaddr; aw_hs_cyc = sn_cyc; aw_wait = 0;
         end else if (sn_awv) begin
            chk("aw_stable", {m_axi.awvalid, m_axi.awaddr}, {1'b1, sn_awaddr});
         end
         if (sn_wv && sn_wr) begin
            got_w = 1; s_wdata = sn_wdata; s_wstrb = sn_wstrb; w_hs_cyc = sn_cyc; w_wait = 0;
         end else if (sn_wv) begin
            chk("w_stable", {m_axi.wvalid, m_axi.wdata}, {1'b1, sn_wdata});
         end
         if (sn_arv && sn_arr) begin
            r_pend = 1; r_wait = 0; s_araddr = sn_araddr; ar_hs_cyc = sn_cyc; ar_wait = 0;
         end else if (sn_arv) begin
            chk("ar_stable", {m_axi.arvalid, m_axi.araddr}, {1'b1, sn_araddr});
         end
         if (got_aw && got_w) begin
            got_aw = 0; got_w = 0;
            if (is_mapped(s_awaddr))
               slv_mem[s_awaddr] = merge(slv_mem.exists(s_awaddr) ? slv_mem[s_awaddr] : 32'h0,
                                         s_wdata, s_wstrb);
            s_bresp = is_mapped(s_awaddr) ? RSP_OKAY : RSP_SLVERR;
            b_pend = 1; b_wait = 0;
         end
         if (sn_bv && sn_br) begin b_pend = 0; b_hs_cyc = sn_cyc; b_hs_count++; end
         if (sn_rv && sn_rr) begin r_pend = 0; r_hs_cyc = sn_cyc; r_hs_count++; end

         m_axi.awready = m_axi.awvalid && (aw_wait >= aw_delay);
         if (m_axi.awvalid) aw_wait++;
         m_axi.wready = m_axi.wvalid && (w_wait >= w_delay);
         if (m_axi.wvalid) w_wait++;
         m_axi.arready = m_axi.arvalid && (ar_wait >= ar_delay);
         if (m_axi.arvalid) ar_wait++;
         m_axi.bvalid = b_pend && (b_wait >= b_delay);
         m_axi.bresp  = s_bresp;
         if (b_pend) b_wait++;
         m_axi.rvalid = r_pend && !hang && (r_wait >= r_delay);
         m_axi.rdata  = is_mapped(s_araddr)
                        ? (slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : 32'h0)
                        : unmapped_data(s_araddr);
         m_axi.rresp  = is_mapped(s_araddr) ? RSP_OKAY : RSP_SLVERR;
         if (r_pend) r_wait++;
      end
      #1;
      sn_awv = m_axi.awvalid; sn_awr = m_axi.awready; sn_awaddr = m_axi.awaddr;
      sn_wv = m_axi.wvalid; sn_wr = m_axi.wready; sn_wdata = m_axi.wdata; sn_wstrb = m_axi.wstrb;
      sn_bv = m_axi.bvalid; sn_br = m_axi.bready;
      sn_arv = m_axi.arvalid; sn_arr = m_axi.arready; sn_araddr = m_axi.araddr;
      sn_rv = m_axi.rvalid; sn_rr = m_axi.rready;
      sn_cyc = cyc;
   end

   // ---------------- response monitor ----------------
   int   rsp_hold = 0, hold_left = 0, rsp_cnt = 0, rsp_first_cyc = 0;
   bit   in_rsp = 0;
   exp_t held;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         rsp_ready = 0; in_rsp = 0;
      end else if (rsp_valid) begin
         if (!in_rsp) begin
            in_rsp = 1; rsp_first_cyc = cyc; hold_left = rsp_hold;
            held = {rsp_rdata, rsp_resp, rsp_timeout};
         end else begin
            chk("rsp_stable", {rsp_rdata, rsp_resp, rsp_timeout}, held);
            chk("cmd_ready_in_rsp", cmd_ready, 0);
         end
         if (hold_left > 0) begin
            rsp_ready = 0; hold_left--;
         end else begin
            rsp_ready = 1; in_rsp = 0; rsp_cnt++;
            chk("rsp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_resp", rsp_resp, e.resp);
               chk("rsp_timeout", rsp_timeout, e.to);
            end
         end
      end else begin
         rsp_ready = 0;
      end
   end

   // ---------------- command driver ----------------
   int acc_cyc = 0;

   task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         chk("cmd_accept_wait", 0, 1);
      end else begin
         acc_cyc = cyc; wv_cycles = 0; b_hs_count = 0; r_hs_count = 0;
         if (wr) begin
            if (is_mapped(a))
               ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 32'h0, d, s);
            e = '{rdata: 32'h0, resp: is_mapped(a) ? RSP_OKAY : RSP_SLVERR, to: 1'b0};
         end else if (hang) begin
            e = '{rdata: 32'h0, resp: RSP_SLVERR, to: 1'b1};
         end else if (is_mapped(a)) begin
            e = '{rdata: ref_mem.exists(a) ? ref_mem[a] : 32'h0, resp: RSP_OKAY, to: 1'b0};
         end else begin
            e = '{rdata: unmapped_data(a), resp: RSP_SLVERR, to: 1'b0};
         end
         exp_q.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
      int target = rsp_cnt + 1;
      int n = 0;
      do_cmd(wr, a, d, s);
      while (rsp_cnt < target && n < 300) begin @(negedge clk); n++; end
      chk("rsp_wait", rsp_cnt >= target, 1);
   endtask

   initial begin
      int n;
      int cnt_before;
      repeat (3) @(negedge clk);
      chk("cmd_ready_in_reset", cmd_ready, 0);
      chk("valids_in_reset", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready}, 0);
      reset = 0;
      @(negedge clk);
      chk("reset_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 0);
      chk("reset_cmd_ready", cmd_ready, 1);

      run(1, 32'h4, 32'hDEADBEEF, 4'hF);
      chk("wr_aw_lat", aw_hs_cyc - acc_cyc, 1);
      chk("wr_w_lat", w_hs_cyc - acc_cyc, 1);
      chk("wr_b_lat", b_hs_cyc - acc_cyc, 2);
      chk("wr_rsp_lat", rsp_first_cyc - acc_cyc, 3);

      run(0, 32'h4, 32'h0, 4'h0);
      chk("rd_ar_lat", ar_hs_cyc - acc_cyc, 1);
      chk("rd_r_lat", r_hs_cyc - acc_cyc, 2);
      chk("rd_rsp_lat", rsp_first_cyc - acc_cyc, 3);

      aw_delay = 3;
      run(1, 32'h8, 32'h1234_5678, 4'b0101);
      aw_delay = 0;
      chk("dly_aw_lat", aw_hs_cyc - acc_cyc, 4);
      chk("dly_w_lat", w_hs_cyc - acc_cyc, 1);
      chk("dly_wvalid_cycles", wv_cycles, 1);
      chk("dly_b_count", b_hs_count, 1);

      run(0, 32'h100, 32'h0, 4'h0);

      rsp_hold = 5;
      run(0, 32'h8, 32'h0, 4'h0);
      rsp_hold = 0;

      r_delay = TO - 1;
      run(0, 32'h4, 32'h0, 4'h0);
      r_delay = 0;
      chk("edge_rsp_lat", rsp_first_cyc - ar_hs_cyc, TO + 1);

      hang = 1;
      run(0, 32'hC, 32'h0, 4'h0);
      chk("to_rsp_lat", rsp_first_cyc - ar_hs_cyc, TO + 1);
      cnt_before = rsp_cnt;
      repeat (3) begin
         @(negedge clk);
         chk("drain_cmd_ready", cmd_ready, 0);
         chk("drain_rready", m_axi.rready, 1);
      end
      hang = 0;
      n = 0;
      while (r_hs_count == 0 && n < 50) begin @(negedge clk); n++; end
      chk("drain_r_hs", r_hs_count, 1);
      chk("drain_exit_cmd_ready", cmd_ready, 1);
      repeat (3) @(negedge clk);
      chk("drain_no_extra_rsp", rsp_cnt, cnt_before);

      for (int i = 0; i < 40; i++) begin
         aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4);
         ar_delay = $urandom_range(0, 4); b_delay = $urandom_range(0, 5);
         r_delay = $urandom_range(0, 5); rsp_hold = $urandom_range(0, 3);
         run($urandom_range(0, 1),
             ($urandom_range(0, 3) == 0) ? 32'h100 + 4 * $urandom_range(0, 15) : 4 * $urandom_range(0, 15),
             $urandom, 4'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      aw_delay = 20; w_delay = 20; ar_delay = 0; b_delay = 0; r_delay = 0; rsp_hold = 0;

      do_cmd(1, 32'h200, 32'hCAFEF00D, 4'hF);
      chk("rst_awvalid_before", m_axi.awvalid, 1);
      reset = 1;
      @(negedge clk);
      chk("rst_valids_cleared", {m_axi.awvalid, m_axi.wvalid}, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      exp_q.delete();
      aw_delay = 0; w_delay = 0;
      reset = 0;
      @(negedge clk);
      chk("post_rst_idle", {cmd_ready, rsp_valid}, 2'b10);

      run(0, 32'h4, 32'h0, 4'h0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
